wbpipe_responder: RTL and testbench
===================================

WBPIPE_RESPONDER -- requirements
Module: wbpipe_responder

Interface
REQ-001 Parameter AW, default 30, word address width.
REQ-002 Parameter LGMEM, default 10, log2 of memory depth in 32-bit words (LGMEM < AW).
REQ-003 Parameter LATENCY, default 2, accept-to-ack cycles; legal range 1..4.
REQ-004 Parameter LGMAXOUT, default 2, log2 of the outstanding-request limit.
REQ-005 i_clk  in  1  clock; all logic on the rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_wb_cyc  in  1  bus cycle active.
REQ-008 i_wb_stb  in  1  request strobe.
REQ-009 i_wb_we  in  1  1 = write, 0 = read.
REQ-010 i_wb_addr  in  AW  word address.
REQ-011 i_wb_data  in  32  write data.
REQ-012 i_wb_sel  in  4  byte enables; bit 3 selects [31:24].
REQ-013 i_stall_req  in  1  bench stall injection.
REQ-014 o_wb_stall  out  1  request not accepted this cycle.
REQ-015 o_wb_ack  out  1  successful completion.
REQ-016 o_wb_data  out  32  read data, qualified by o_wb_ack.
REQ-017 o_wb_err  out  1  bus error completion.

Function
REQ-018 The block SHALL be a Wishbone B4 pipelined responder, the slave end for a pipelined bus master.
REQ-019 Accept SHALL be i_wb_cyc && i_wb_stb && !o_wb_stall.
REQ-020 o_wb_stall SHALL be combinational: i_stall_req || (outstanding == 2**LGMAXOUT).
REQ-021 outstanding SHALL be a registered LGMAXOUT+1-bit count: +1 on accept, -1 on ack or err, unchanged when both occur in the same cycle.
REQ-022 An address SHALL be in range iff i_wb_addr[AW-1:LGMEM] == 0.
REQ-023 An accepted in-range write SHALL update only the sel-enabled bytes of mem[addr[LGMEM-1:0]] at the accept edge.
REQ-024 An accepted in-range read SHALL capture mem[addr] at the accept edge; a write accepted in an earlier cycle SHALL be visible.
REQ-025 An accepted out-of-range request SHALL not modify memory and SHALL complete with o_wb_err instead of o_wb_ack.
REQ-026 Completions SHALL use a LATENCY-stage shift pipeline of {valid, err, data}; an accept at edge N SHALL produce exactly one o_wb_ack or o_wb_err pulse during cycle N+LATENCY-1 (LATENCY registered stages).
REQ-027 Completions SHALL return in acceptance order, one per cycle; back-to-back accepts SHALL yield back-to-back completions.
REQ-028 o_wb_data SHALL equal the captured read data during a read ack and 0 in every other cycle, including write acks and errors.
REQ-029 o_wb_ack and o_wb_err SHALL never be asserted together.
REQ-030 When i_wb_cyc is low, all pipeline valid bits SHALL clear at the next edge, outstanding SHALL reset to 0, and no ack or err SHALL be driven while i_wb_cyc is low.
REQ-031 A cycle abort SHALL not undo memory writes already accepted.
REQ-032 i_wb_stb while i_wb_cyc is low SHALL be ignored.
REQ-033 i_stall_req SHALL block new accepts only; in-flight completions SHALL continue.

Reset
REQ-034 On i_reset, the pipeline valid bits and outstanding SHALL clear to 0, and o_wb_ack = 0, o_wb_err = 0, and o_wb_data = 0 from the next cycle.
REQ-035 Reset mid-transfer SHALL drop all in-flight completions.
REQ-036 Memory contents SHALL not be reset.
REQ-037 o_wb_stall after reset SHALL equal i_stall_req.

Verification
REQ-038 Write 0xDEADBEEF to addr 5 with sel=4'hF, then read addr 5 -> write ack, then read ack with o_wb_data = 0xDEADBEEF exactly LATENCY cycles after each accept.
REQ-039 Write 0x000000AA to addr 5 with sel=4'b0001, then read -> 0xDEADBEAA.
REQ-040 Read addr 2**LGMEM -> o_wb_err at LATENCY, o_wb_ack = 0, o_wb_data = 0, memory unchanged.
REQ-041 With LATENCY=4 and LGMAXOUT=1, hold stb for 6 cycles -> stall after 2 accepts, 6 completions in order, outstanding never above 2.
REQ-042 Accept 2 reads, drop i_wb_cyc for one cycle -> no ack or err, outstanding = 0; a fresh read then acks normally.
REQ-043 Assert i_reset with 3 requests in flight -> no completions after reset; o_wb_ack, o_wb_err, and o_wb_data = 0.

Source files
------------

// File: rtl/wbpipe_responder.sv
// Wishbone B4 pipelined responder backed by a byte-writable word memory.
// Completions travel a fixed-depth shift pipeline so they return in acceptance order.
module wbpipe_responder #(
  parameter int AW       = 30,
  parameter int LGMEM    = 10,
  parameter int LATENCY  = 2,
  parameter int LGMAXOUT = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [31:0]   i_wb_data,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_stall_req,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [31:0]   o_wb_data,
  output logic          o_wb_err
);

  localparam int                MAX_OUT_I = 2 ** LGMAXOUT;
  localparam logic [LGMAXOUT:0] MAX_OUT   = MAX_OUT_I[LGMAXOUT:0];

  logic [31:0]        mem [0:(2**LGMEM)-1];
  logic [LGMAXOUT:0]  outstanding;
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_data [LATENCY];
  logic               accept;
  logic               in_range;
  logic [LGMEM-1:0]   word;
  logic [31:0]        rd_word;
  logic               done;

  assign o_wb_stall = i_stall_req || (outstanding == MAX_OUT);
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign in_range   = (i_wb_addr[AW-1:LGMEM] == '0);
  assign word       = i_wb_addr[LGMEM-1:0];
  assign rd_word    = mem[word];

  // Memory is deliberately not reset; writes land at the accept edge.
  always_ff @(posedge i_clk) begin
    if (accept && in_range && i_wb_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) mem[word][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // Payload shifts freely; only the valid bits carry meaning.
  always_ff @(posedge i_clk) begin
    pipe_err[0]  <= !in_range;
    pipe_data[0] <= (in_range && !i_wb_we) ? rd_word : '0;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_err[i]  <= pipe_err[i-1];
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  assign done      = pipe_valid[LATENCY-1] && i_wb_cyc;
  assign o_wb_ack  = done && !pipe_err[LATENCY-1];
  assign o_wb_err  = done && pipe_err[LATENCY-1];
  assign o_wb_data = o_wb_ack ? pipe_data[LATENCY-1] : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      outstanding <= '0;
    end else begin
      case ({accept, done})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_wbpipe_responder.sv
// Bench for wbpipe_responder: directed scenarios then random traffic, all checked
// against a queue-based reference model with per-request due cycles.
module tb_wbpipe_responder;
  localparam int AW     = 12;
  localparam int LGMEM  = 6;
  localparam int LAT    = 4;
  localparam int LGMO   = 1;
  localparam int DEPTH  = 2 ** LGMEM;
  localparam int MAXOUT = 2 ** LGMO;

  logic          clk = 1'b0;
  logic          rst, cyc, stb, we, stall_req;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    sel;
  logic          stall, ack, err;
  logic [31:0]   rdata;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] data;
  } cpl_t;

  cpl_t        q[$];
  logic [31:0] model_mem [DEPTH];
  int          cyc_n = 0;
  int          tests = 0;
  int          fails = 0;
  bit          chk = 0;
  bit          accepted;

  always #5 clk = ~clk;

  wbpipe_responder #(
    .AW(AW), .LGMEM(LGMEM), .LATENCY(LAT), .LGMAXOUT(LGMO)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .i_stall_req(stall_req),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata), .o_wb_err(err)
  );

  // One bus cycle: check outputs mid-cycle, then advance the model past the edge.
  task automatic step();
    logic        exp_stall, exp_ack, exp_err;
    logic [31:0] exp_data;
    bit          pop, inr;
    int          idx;
    cpl_t        c;
    @(negedge clk);
    exp_stall = stall_req || (q.size() == MAXOUT);
    pop = (q.size() > 0) && (q[0].due == cyc_n);
    exp_ack = 1'b0; exp_err = 1'b0; exp_data = '0;
    if (pop && cyc) begin
      exp_ack  = !q[0].err;
      exp_err  = q[0].err;
      exp_data = q[0].err ? 32'h0 : q[0].data;
    end
    if (chk) begin
      tests++;
      assert (stall === exp_stall) else begin
        fails++; $error("FAIL stall cyc=%0d got=%b exp=%b", cyc_n, stall, exp_stall);
      end
      tests++;
      assert (ack === exp_ack) else begin
        fails++; $error("FAIL ack cyc=%0d got=%b exp=%b", cyc_n, ack, exp_ack);
      end
      tests++;
      assert (err === exp_err) else begin
        fails++; $error("FAIL err cyc=%0d got=%b exp=%b", cyc_n, err, exp_err);
      end
      tests++;
      assert (rdata === exp_data) else begin
        fails++; $error("FAIL data cyc=%0d got=%h exp=%h", cyc_n, rdata, exp_data);
      end
    end
    accepted = 1'b0;
    if (pop) q.pop_front();
    if (rst || !cyc) begin
      q.delete();
    end else if (stb && !exp_stall) begin
      accepted = 1'b1;
      inr = (addr[AW-1:LGMEM] == '0);
      idx = int'(addr[LGMEM-1:0]);
      c.due  = cyc_n + LAT;
      c.err  = !inr;
      c.data = (inr && !we) ? model_mem[idx] : 32'h0;
      q.push_back(c);
      if (inr && we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic req(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    do begin
      step();
      n++;
    end while (!accepted && n < 64);
    tests++;
    assert (accepted) else begin
      fails++; $error("FAIL accept_timeout addr=%0h got=0 exp=1", a);
    end
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0;
    wdata = '0; sel = '0; stall_req = 1'b0;
    step();
    chk = 1'b1;
    step();
    stall_req = 1'b1;
    step();
    rst = 1'b0; stall_req = 1'b0; cyc = 1'b1;
    idle(2);

    for (int i = 0; i < DEPTH; i++) req(1'b1, AW'(i), $urandom, 4'hF);
    idle(LAT + 2);

    req(1'b1, 12'd5, 32'hDEADBEEF, 4'hF);
    idle(LAT);
    req(1'b0, 12'd5, 32'h0, 4'h0);
    idle(LAT + 1);

    req(1'b1, 12'd5, 32'h000000AA, 4'b0001);
    req(1'b0, 12'd5, 32'h0, 4'h0);
    idle(LAT + 1);

    req(1'b0, AW'(DEPTH), 32'h0, 4'h0);
    req(1'b1, AW'(DEPTH + 5), 32'h12345678, 4'hF);
    req(1'b0, 12'd5, 32'h0, 4'h0);
    idle(LAT + 1);

    repeat (6) req(1'b0, AW'($urandom_range(0, DEPTH - 1)), 32'h0, 4'h0);
    idle(LAT + 1);

    req(1'b0, 12'd1, 32'h0, 4'h0);
    req(1'b0, 12'd2, 32'h0, 4'h0);
    cyc = 1'b0;
    step();
    cyc = 1'b1;
    req(1'b0, 12'd3, 32'h0, 4'h0);
    idle(LAT + 1);

    req(1'b0, 12'd3, 32'h0, 4'h0);
    req(1'b0, 12'd4, 32'h0, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(LAT + 2);

    repeat (400) begin
      rst       = ($urandom_range(0, 99) < 2);
      cyc       = rst ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) != 0);
      stb       = !rst && ($urandom_range(0, 2) != 0);
      we        = 1'($urandom_range(0, 1));
      addr      = AW'($urandom_range(0, DEPTH + 7));
      wdata     = $urandom;
      sel       = 4'($urandom_range(0, 15));
      stall_req = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; cyc = 1'b1; stall_req = 1'b0;
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
